// File: rtl/cordic_pipe16_if.sv
// Sample/result bundle for the free-running sin/cos engine.
// All words are signed Q2.14; there is no handshake, so every field is valid every cycle.
interface cordic_pipe16_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] theta_in;
    logic signed [WIDTH-1:0] cosx;
    logic signed [WIDTH-1:0] sinx;

    modport master (output x_in, output y_in, output theta_in, input cosx, input sinx);
    modport slave  (input x_in, input y_in, input theta_in, output cosx, output sinx);
endinterface

// File: rtl/cordic_pipe16.sv
// Fully pipelined rotation-mode CORDIC: one micro-rotation per register stage,
// one sample in and one result out per clock, latency STAGES edges.
module cordic_pipe16 #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 16,
    parameter int IW     = 18
) (
    input  logic           clk,
    input  logic           rst,
    cordic_pipe16_if.slave io
);

    function automatic logic signed [IW-1:0] atan_lut(input int i);
        logic signed [IW-1:0] r;
        r = '0;
        case (i)
            0:  r = IW'(12868);
            1:  r = IW'(7596);
            2:  r = IW'(4014);
            3:  r = IW'(2037);
            4:  r = IW'(1023);
            5:  r = IW'(512);
            6:  r = IW'(256);
            7:  r = IW'(128);
            8:  r = IW'(64);
            9:  r = IW'(32);
            10: r = IW'(16);
            11: r = IW'(8);
            12: r = IW'(4);
            13: r = IW'(2);
            14: r = IW'(1);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Clamp an internal word to the output range when the guard bits disagree with the sign.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        logic signed [WIDTH-1:0] r;
        if ((&v[IW-1:WIDTH-1]) || !(|v[IW-1:WIDTH-1]))
            r = v[WIDTH-1:0];
        else if (v[IW-1])
            r = {1'b1, {(WIDTH-1){1'b0}}};
        else
            r = {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

    logic signed [IW-1:0] x_p [STAGES];
    logic signed [IW-1:0] y_p [STAGES];
    // The last stage's angle residual is never observed, so it is not kept.
    logic signed [IW-1:0] z_p [STAGES-1];

    logic signed [IW-1:0] x_op [STAGES];
    logic signed [IW-1:0] y_op [STAGES];
    logic signed [IW-1:0] z_op [STAGES];

    always_comb begin
        x_op[0] = {{(IW-WIDTH){io.x_in[WIDTH-1]}}, io.x_in};
        y_op[0] = {{(IW-WIDTH){io.y_in[WIDTH-1]}}, io.y_in};
        z_op[0] = {{(IW-WIDTH){io.theta_in[WIDTH-1]}}, io.theta_in};
        for (int i = 1; i < STAGES; i++) begin
            x_op[i] = x_p[i-1];
            y_op[i] = y_p[i-1];
            z_op[i] = z_p[i-1];
        end
    end

    // Stage boundary: each x_p/y_p/z_p[i] holds the result of micro-rotation i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                x_p[i] <= '0;
                y_p[i] <= '0;
            end
            for (int i = 0; i < STAGES-1; i++) begin
                z_p[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (!z_op[i][IW-1]) begin
                    x_p[i] <= x_op[i] - (y_op[i] >>> i);
                    y_p[i] <= y_op[i] + (x_op[i] >>> i);
                end else begin
                    x_p[i] <= x_op[i] + (y_op[i] >>> i);
                    y_p[i] <= y_op[i] - (x_op[i] >>> i);
                end
            end
            for (int i = 0; i < STAGES-1; i++) begin
                if (!z_op[i][IW-1])
                    z_p[i] <= z_op[i] - atan_lut(i);
                else
                    z_p[i] <= z_op[i] + atan_lut(i);
            end
        end
    end

    assign io.cosx = sat(x_p[STAGES-1]);
    assign io.sinx = sat(y_p[STAGES-1]);

endmodule

// File: tb/tb_cordic_pipe16.sv
// Directed bench for cordic_pipe16: reset behaviour, exact 16-edge latency,
// hand-computed key angles and an in-order back-to-back sweep across +/-pi/2.
module tb_cordic_pipe16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   t;
    int   exp_c [0:255];
    int   exp_s [0:255];

    cordic_pipe16_if io ();

    cordic_pipe16 dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_cmp++;
        if (obs - exp > tol || exp - obs > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Apply one sample, advance one edge, then check whatever is due at the output now.
    task automatic step(input logic signed [15:0] th, input int ec, input int es);
        io.theta_in = th;
        exp_c[t] = ec;
        exp_s[t] = es;
        @(posedge clk);
        #1;
        t++;
        if (t >= 16) begin
            check($sformatf("cos[%0d]", t-16), int'(io.cosx), exp_c[t-16], 8);
            check($sformatf("sin[%0d]", t-16), int'(io.sinx), exp_s[t-16], 8);
        end else begin
            check($sformatf("cos_fill[%0d]", t), int'(io.cosx), 0, 0);
            check($sformatf("sin_fill[%0d]", t), int'(io.sinx), 0, 0);
        end
    endtask

    initial begin
        int   th;
        real  a;
        n_cmp = 0;
        n_bad = 0;
        t = 0;
        rst = 1'b1;
        io.x_in = 16'sh26DD;
        io.y_in = 16'sh0000;
        io.theta_in = 16'sh3244;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_cos", int'(io.cosx), 0, 0);
        check("rst_hold_sin", int'(io.sinx), 0, 0);
        rst = 1'b0;

        step(16'sh3244, 11585, 11585);
        step(16'sh0000, 16384, 0);
        step(16'shCDBC, 11585, -11585);
        step(16'sh6488, 0, 16384);

        for (int k = 0; k < 64; k++) begin
            th = -25736 + k * 817;
            a = real'(th) / 16384.0;
            step(16'(th), int'($floor(16384.0 * $cos(a) + 0.5)),
                 int'($floor(16384.0 * $sin(a) + 0.5)));
        end
        for (int k = 0; k < 16; k++) step(16'sh0000, 16384, 0);

        // Fill the pipe with nonzero work, then reset asynchronously between edges.
        for (int k = 0; k < 3; k++) step(16'sh3244, 11585, 11585);
        check("pre_rst_cos", int'(io.cosx), 16384, 8);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_cos", int'(io.cosx), 0, 0);
        check("async_rst_sin", int'(io.sinx), 0, 0);
        @(posedge clk);
        #1;
        check("rst_held_cos", int'(io.cosx), 0, 0);
        check("rst_held_sin", int'(io.sinx), 0, 0);
        rst = 1'b0;

        t = 0;
        step(16'shCDBC, 11585, -11585);
        step(16'sh6488, 0, 16384);
        for (int k = 0; k < 16; k++) step(16'sh0000, 16384, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
